pulse_width_modulation: RTL and testbench
=========================================

# pulse_width_modulation

Fixed-duty PWM source for the drive motors. A single free-running period counter feeds five comparators. Each comparator produces one speed-grade PWM waveform: full, veer, hard turn, ninety-degree turn, and fast ninety-degree turn. The steering/motor-select logic downstream picks one waveform per wheel.

## Interface
Parameters:
- `CNT_WIDTH`, 10: width of period counter.
- `PERIOD`, 1000: counter period in clocks; 25 kHz PWM at the 25 MHz `clk`. Legal range 2..2^CNT_WIDTH.
- `FULL_DUTY`, 1000: high clocks per period on `fullSpeedPwm`.
- `VEER_DUTY`, 750: high clocks per period on `veerSpeedPwm`.
- `HARD_DUTY`, 500: high clocks per period on `hardSpeedPwm`.
- `NINETY_DUTY`, 300: high clocks per period on `ninetySpeedPwm`.
- `NINETY_FAST_DUTY`, 600: high clocks per period on `ninetyFastSpeedPwm`.

Ports:
- `clk` in, 1: system clock, rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `fullSpeedPwm` out, 1: PWM at FULL_DUTY/PERIOD.
- `veerSpeedPwm` out, 1: PWM at VEER_DUTY/PERIOD.
- `hardSpeedPwm` out, 1: PWM at HARD_DUTY/PERIOD.
- `ninetySpeedPwm` out, 1: PWM at NINETY_DUTY/PERIOD.
- `ninetyFastSpeedPwm` out, 1: PWM at NINETY_FAST_DUTY/PERIOD.

Clock and reset are as stated in the "Already decided" line: one clock, synchronous active-high reset.

## Operation
- Counter `cnt` (CNT_WIDTH bits):
  - increments by 1 each clock;
  - wraps from PERIOD-1 to 0.
- Each output is registered: `out <= (cnt < DUTY)`. The comparison is unsigned.
- DUTY = 0: output is held constantly 0.
- DUTY >= PERIOD: output is held constantly 1. Clamp internally; no wrap artifacts.
- All channels share one counter, so every channel's rising edge aligns at the same cycle, i.e. the cycle after `cnt`=0.
- There are no enables or runtime duty inputs. Duties are elaboration-time constants only.

## Timing
- Reset behaviour: while `rst`=1 at a rising edge, `cnt` is set to 0 and all five outputs are set to 0.
- Reset dominates. An assertion mid-period aborts the current period; there is no completion of the current pulse.
- First edge with `rst`=0: outputs load `(0 < DUTY)`, so nonzero-duty channels go high; `cnt` becomes 1.
- Latency:
  - output value at edge k+1 reflects `cnt` value at edge k (one-cycle register delay);
  - high time is exactly DUTY clocks per PERIOD clocks;
  - the period is exactly PERIOD clocks.
- Falling edge of a channel: the edge after `cnt` = DUTY-1 is the last high sample. The output is low from the edge where `cnt`=DUTY is compared.
- Wrap: `cnt`=PERIOD-1 → 0 with no skipped or doubled count.

## Structure
- Shared package `pwm_pkg` holds:
  - `CNT_WIDTH`;
  - default `PERIOD`;
  - the five default duty constants;
  - the clamp function `min(duty, PERIOD)`.
- Sub-module `pwm_channel`:
  - parameters: DUTY, PERIOD, CNT_WIDTH;
  - inputs: `clk`, `rst`, `cnt`;
  - output: registered `pwm`.
- The top holds the counter and five `pwm_channel` instances.

## Test plan
- Reset hold:
  - stimulus: `rst`=1 for 5 clocks;
  - required: all outputs 0, internal `cnt`=0.
- Release:
  - stimulus: deassert `rst`, then run 1000 clocks;
  - required high-clock counts: full=1000, veer=750, hard=500, ninety=300, ninetyFast=600.
  - required: the rising edge of all nonzero channels appears at the first post-reset edge.
- Period check:
  - stimulus: measure rising-to-rising edge of `hardSpeedPwm` over 3 periods;
  - required: exactly 1000 clocks each.
  - required: `fullSpeedPwm` never toggles after release.
- Mid-period reset:
  - stimulus: assert `rst` for 1 clock at `cnt`=400;
  - required: all outputs 0 on the next edge; a new period begins with the high phase on the following edge.
- Boundary duties:
  - stimulus: instantiate with `NINETY_DUTY`=0 and `VEER_DUTY`=1200;
  - required: `ninetySpeedPwm` constant 0 and `veerSpeedPwm` constant 1 across 3 periods.
- Small period:
  - stimulus: `PERIOD`=4, `HARD_DUTY`=2;
  - required: `hardSpeedPwm` follows the pattern 1,1,0,0 repeating from the first post-reset edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the drive-motor PWM source.
package pwm_pkg;

  localparam int unsigned DEF_CNT_WIDTH        = 10;
  localparam int unsigned DEF_PERIOD           = 1000;
  localparam int unsigned DEF_FULL_DUTY        = 1000;
  localparam int unsigned DEF_VEER_DUTY        = 750;
  localparam int unsigned DEF_HARD_DUTY        = 500;
  localparam int unsigned DEF_NINETY_DUTY      = 300;
  localparam int unsigned DEF_NINETY_FAST_DUTY = 600;

  // Saturate a duty at the period so over-range duties read as always-high.
  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
    return (duty < period) ? duty : period;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM comparator: registered (cnt < clamped DUTY).
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY      = DEF_HARD_DUTY,
  parameter int unsigned PERIOD    = DEF_PERIOD,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] cnt,
  output logic                 pwm
);

  // One extra bit so a clamped duty equal to 2^CNT_WIDTH still compares correctly.
  localparam int unsigned CMP_W  = CNT_WIDTH + 1;
  localparam int unsigned DUTY_C = clamp_duty(DUTY, PERIOD);

  logic             r_pwm;
  logic [CMP_W-1:0] w_cnt_ext;

  assign w_cnt_ext = {1'b0, cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (w_cnt_ext < CMP_W'(DUTY_C));
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/pulse_width_modulation.sv
// Fixed-duty PWM source: one shared period counter feeding five speed-grade channels.
module pulse_width_modulation
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH        = DEF_CNT_WIDTH,
  parameter int unsigned PERIOD           = DEF_PERIOD,
  parameter int unsigned FULL_DUTY        = DEF_FULL_DUTY,
  parameter int unsigned VEER_DUTY        = DEF_VEER_DUTY,
  parameter int unsigned HARD_DUTY        = DEF_HARD_DUTY,
  parameter int unsigned NINETY_DUTY      = DEF_NINETY_DUTY,
  parameter int unsigned NINETY_FAST_DUTY = DEF_NINETY_FAST_DUTY
) (
  input  logic clk,
  input  logic rst,
  output logic fullSpeedPwm,
  output logic veerSpeedPwm,
  output logic hardSpeedPwm,
  output logic ninetySpeedPwm,
  output logic ninetyFastSpeedPwm
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // Free-running period counter, wraps PERIOD-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_WIDTH'(PERIOD - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  pwm_channel #(.DUTY(FULL_DUTY), .PERIOD(PERIOD), .CNT_WIDTH(CNT_WIDTH)) u_full (
    .clk(clk), .rst(rst), .cnt(r_cnt), .pwm(fullSpeedPwm)
  );

  pwm_channel #(.DUTY(VEER_DUTY), .PERIOD(PERIOD), .CNT_WIDTH(CNT_WIDTH)) u_veer (
    .clk(clk), .rst(rst), .cnt(r_cnt), .pwm(veerSpeedPwm)
  );

  pwm_channel #(.DUTY(HARD_DUTY), .PERIOD(PERIOD), .CNT_WIDTH(CNT_WIDTH)) u_hard (
    .clk(clk), .rst(rst), .cnt(r_cnt), .pwm(hardSpeedPwm)
  );

  pwm_channel #(.DUTY(NINETY_DUTY), .PERIOD(PERIOD), .CNT_WIDTH(CNT_WIDTH)) u_ninety (
    .clk(clk), .rst(rst), .cnt(r_cnt), .pwm(ninetySpeedPwm)
  );

  pwm_channel #(.DUTY(NINETY_FAST_DUTY), .PERIOD(PERIOD), .CNT_WIDTH(CNT_WIDTH)) u_nfast (
    .clk(clk), .rst(rst), .cnt(r_cnt), .pwm(ninetyFastSpeedPwm)
  );

endmodule

// File: tb/tb_pulse_width_modulation.sv
// Bench for pulse_width_modulation: default, boundary-duty and small-period builds vs. a reference model.
module tb_pulse_width_modulation;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [4:0] o_def, o_bnd, o_sml;

  pulse_width_modulation dut (
    .clk(clk), .rst(rst),
    .fullSpeedPwm(o_def[0]), .veerSpeedPwm(o_def[1]), .hardSpeedPwm(o_def[2]),
    .ninetySpeedPwm(o_def[3]), .ninetyFastSpeedPwm(o_def[4])
  );

  pulse_width_modulation #(.NINETY_DUTY(0), .VEER_DUTY(1200)) dut_bnd (
    .clk(clk), .rst(rst),
    .fullSpeedPwm(o_bnd[0]), .veerSpeedPwm(o_bnd[1]), .hardSpeedPwm(o_bnd[2]),
    .ninetySpeedPwm(o_bnd[3]), .ninetyFastSpeedPwm(o_bnd[4])
  );

  pulse_width_modulation #(.PERIOD(4), .HARD_DUTY(2)) dut_sml (
    .clk(clk), .rst(rst),
    .fullSpeedPwm(o_sml[0]), .veerSpeedPwm(o_sml[1]), .hardSpeedPwm(o_sml[2]),
    .ninetySpeedPwm(o_sml[3]), .ninetyFastSpeedPwm(o_sml[4])
  );

  // Channel order: full, veer, hard, ninety, ninetyFast.
  int def_d[5] = '{1000, 750, 500, 300, 600};
  int bnd_d[5] = '{1000, 1200, 500, 0, 600};
  int sml_d[5] = '{1000, 750, 2, 300, 600};
  string ch_name[5] = '{"full", "veer", "hard", "ninety", "nfast"};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: k-th clock after release (k from 0) is high iff (k mod P) < min(D, P).
  function automatic int ref_level(input int k, input int duty, input int period);
    int d;
    d = (duty < period) ? duty : period;
    return ((k % period) < d) ? 1 : 0;
  endfunction

  int n_since = 0;
  int cyc = 0;
  int hi_cnt[5];
  bit counting = 1'b0;
  int full_low = 0;
  bit prev_hard = 1'b0;
  int rise_q[$];

  // Advance one edge, update the model, compare every channel of every build.
  task automatic step();
    bit was_rst;
    was_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 5; c++) begin
      if (was_rst) begin
        check({"rst_", ch_name[c]}, int'(o_def[c]), 0);
        check({"rst_bnd_", ch_name[c]}, int'(o_bnd[c]), 0);
        check({"rst_sml_", ch_name[c]}, int'(o_sml[c]), 0);
      end else begin
        check({"def_", ch_name[c]}, int'(o_def[c]), ref_level(n_since, def_d[c], 1000));
        check({"bnd_", ch_name[c]}, int'(o_bnd[c]), ref_level(n_since, bnd_d[c], 1000));
        check({"sml_", ch_name[c]}, int'(o_sml[c]), ref_level(n_since, sml_d[c], 4));
      end
    end
    if (was_rst) n_since = 0;
    else n_since++;
    if (counting) begin
      for (int c = 0; c < 5; c++) if (o_def[c]) hi_cnt[c]++;
      if (!o_def[0]) full_low++;
      if (o_def[2] && !prev_hard) rise_q.push_back(cyc);
    end
    prev_hard = o_def[2];
  endtask

  initial begin
    int waited;
    int exp_pat[4];
    exp_pat = '{1, 1, 0, 0};

    // Reset hold.
    rst = 1'b1;
    repeat (5) step();
    check("reset_cnt", int'(dut.r_cnt), 0);

    // Release: first edge raises every nonzero channel, then 1000-clock high counts.
    rst = 1'b0;
    for (int c = 0; c < 5; c++) hi_cnt[c] = 0;
    counting = 1'b1;
    prev_hard = 1'b0;
    step();
    check("first_edge_def", int'(o_def), 31);
    check("first_edge_bnd", int'(o_bnd), 23);
    for (int i = 0; i < 3; i++) begin
      check("sml_pattern", int'(o_sml[2]), exp_pat[i % 4]);
      step();
    end
    check("sml_pattern_3", int'(o_sml[2]), exp_pat[3]);
    repeat (996) step();
    for (int c = 0; c < 5; c++) check({"high_cnt_", ch_name[c]}, hi_cnt[c], def_d[c]);

    // Period check on hard: three rising-to-rising intervals.
    repeat (3000) step();
    check("hard_rises", rise_q.size(), 4);
    for (int i = 1; i < rise_q.size(); i++)
      check("hard_period", rise_q[i] - rise_q[i-1], 1000);
    check("full_never_low", full_low, 0);
    counting = 1'b0;

    // Mid-period reset at cnt = 400.
    waited = 0;
    while (int'(dut.r_cnt) != 400 && waited < 2000) begin
      step();
      waited++;
    end
    check("wait_cnt400", int'(dut.r_cnt), 400);
    rst = 1'b1;
    step();
    check("mid_rst_outs", int'(o_def), 0);
    rst = 1'b0;
    step();
    check("mid_restart_hard", int'(o_def[2]), 1);
    check("mid_restart_cnt", int'(dut.r_cnt), 1);

    // Randomised runs separated by short reset pulses.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 1500)) step();
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      rst = 1'b0;
    end
    repeat (50) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
